// File: rtl/mem_bist_ctrl.sv
// mem_bist_ctrl
//   Built-in self-test sequencer for a single-port memory (default 32x8).
//   Sits directly upstream of the memory and drives its address, write data and
//   read/write strobes. A run writes all-zero, reads it back, writes
//   data-equals-address and reads that back. Every read is compared one cycle
//   later against the value that was written. The first miscompare is captured
//   and all miscompares are counted.
//
//   Optional feature macro: MEM_BIST_LFSR_EN
//     When defined, two more phases (WR_LFSR, RD_LFSR) run after RD_ADDR. They
//     use an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5). This build
//     needs DATA_WIDTH == 8.
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   start            run request, only honoured while idle
//   busy             high whenever the sequencer is not idle
//   done             one-cycle pulse in the FINISH cycle
//   pass             1 = no miscompares; valid from done until the next start
//   phase            current state code
//   mem_addr         memory address
//   mem_data_in      memory write data
//   mem_write        memory write strobe
//   mem_read         memory read strobe
//   mem_data_out     memory read data, valid one cycle after mem_read
//   fail_count       saturating miscompare count for the current run
//   first_fail_addr  address of the first miscompare
//   first_fail_exp   expected data at the first miscompare
//   first_fail_act   actual data at the first miscompare

module mem_bist_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [2:0]            phase,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_write,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic [7:0]            fail_count,
    output logic [ADDR_WIDTH-1:0] first_fail_addr,
    output logic [DATA_WIDTH-1:0] first_fail_exp,
    output logic [DATA_WIDTH-1:0] first_fail_act
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ZERO = 3'd1,
        ST_RD_ZERO = 3'd2,
        ST_WR_ADDR = 3'd3,
        ST_RD_ADDR = 3'd4,
`ifdef MEM_BIST_LFSR_EN
        ST_WR_LFSR = 3'd5,
        ST_RD_LFSR = 3'd6,
        ST_FINISH  = 3'd7
`else
        ST_FINISH  = 3'd5
`endif
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   cnt_data;
    logic [DATA_WIDTH-1:0]   exp_d;
    logic                    last;
    logic                    run_start;

    // Read pipeline: what was read, and what it should have been.
    logic                    rd_valid;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [DATA_WIDTH-1:0]   rd_exp;
    logic                    miscompare;
    logic                    pass_now;
    logic                    pass_q;

`ifdef MEM_BIST_LFSR_EN
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_next;

    if (DATA_WIDTH != 8) begin : g_lfsr_width_check
        $error("mem_bist_ctrl: MEM_BIST_LFSR_EN needs DATA_WIDTH == 8");
    end

    assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    // The LFSR restarts from the seed at the start of each LFSR phase. The read
    // phase then regenerates exactly the sequence that the write phase stored.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else if ((state_d != state_q) &&
                     ((state_d == ST_WR_LFSR) || (state_d == ST_RD_LFSR))) begin
            lfsr_q <= LFSR_SEED;
        end else if ((state_q == ST_WR_LFSR) || (state_q == ST_RD_LFSR)) begin
            lfsr_q <= lfsr_next;
        end
    end
`endif

    assign cnt_data  = DATA_WIDTH'(cnt_q);
    assign last      = (cnt_q == CNT_LAST);
    assign run_start = (state_q == ST_IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and memory-side outputs. The address counter runs only in
    // read and write phases. It wraps to 0 on the last word, which is also
    // the cycle where the phase changes.
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        busy        = (state_q != ST_IDLE);
        done        = 1'b0;
        phase       = state_q;
        mem_addr    = '0;
        mem_data_in = '0;
        mem_write   = 1'b0;
        mem_read    = 1'b0;
        exp_d       = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_WR_ZERO;
            end
            ST_WR_ZERO: begin
                mem_write = 1'b1;
                mem_addr  = cnt_q;
                if (last) state_d = ST_RD_ZERO;
            end
            ST_RD_ZERO: begin
                mem_read = 1'b1;
                mem_addr = cnt_q;
                if (last) state_d = ST_WR_ADDR;
            end
            ST_WR_ADDR: begin
                mem_write   = 1'b1;
                mem_addr    = cnt_q;
                mem_data_in = cnt_data;
                if (last) state_d = ST_RD_ADDR;
            end
            ST_RD_ADDR: begin
                mem_read = 1'b1;
                mem_addr = cnt_q;
                exp_d    = cnt_data;
`ifdef MEM_BIST_LFSR_EN
                if (last) state_d = ST_WR_LFSR;
`else
                if (last) state_d = ST_FINISH;
`endif
            end
`ifdef MEM_BIST_LFSR_EN
            ST_WR_LFSR: begin
                mem_write   = 1'b1;
                mem_addr    = cnt_q;
                mem_data_in = DATA_WIDTH'(lfsr_q);
                if (last) state_d = ST_RD_LFSR;
            end
            ST_RD_LFSR: begin
                mem_read = 1'b1;
                mem_addr = cnt_q;
                exp_d    = DATA_WIDTH'(lfsr_q);
                if (last) state_d = ST_FINISH;
            end
`endif
            ST_FINISH: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (mem_read || mem_write) cnt_d = last ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_addr  <= '0;
            rd_exp   <= '0;
        end else begin
            rd_valid <= mem_read;
            rd_addr  <= mem_addr;
            rd_exp   <= exp_d;
        end
    end

    // The compare stage is decoupled from the state register, so the last read
    // of a phase is still checked in the first cycle of the following state.
    // In FINISH, pass must already include the compare happening that cycle.
    always_comb begin
        miscompare = rd_valid && (mem_data_out != rd_exp);
        pass_now   = (fail_count == 8'd0) && !miscompare;
        pass       = (state_q == ST_FINISH) ? pass_now : pass_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fail_count      <= 8'd0;
            first_fail_addr <= '0;
            first_fail_exp  <= '0;
            first_fail_act  <= '0;
            pass_q          <= 1'b0;
        end else if (run_start) begin
            fail_count      <= 8'd0;
            first_fail_addr <= '0;
            first_fail_exp  <= '0;
            first_fail_act  <= '0;
            pass_q          <= 1'b0;
        end else begin
            if (miscompare) begin
                if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
                if (fail_count == 8'd0) begin
                    first_fail_addr <= rd_addr;
                    first_fail_exp  <= rd_exp;
                    first_fail_act  <= mem_data_out;
                end
            end
            if (state_q == ST_FINISH) pass_q <= pass_now;
        end
    end

endmodule
